// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------
// serial_adder_pkg : shared state encodings and default width
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  localparam int C_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
//------------------------------------------------------------------
// fa_cell : gate-level full adder (two half-adder stages plus OR)
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  assign w_s1 = x ^ y;
  assign w_c1 = x & y;
  assign s    = w_s1 ^ z;
  assign w_c2 = w_s1 & z;
  assign c    = w_c1 | w_c2;

endmodule

`default_nettype wire

// File: rtl/serial_adder_8bit.sv
//------------------------------------------------------------------
// serial_adder_8bit : bit-serial adder, one result bit per clock
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

module serial_adder_8bit
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                 c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_sh_a;
  logic [WIDTH-1:0]   r_sh_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic [WIDTH-1:0]   w_res_next;
  logic               w_accept;
  logic               w_last;
  logic               w_run;
  logic               w_s;
  logic               w_c;

  fa_cell u_fa (
    .x (r_sh_a[0]),
    .y (r_sh_b[0]),
    .z (r_carry),
    .s (w_s),
    .c (w_c)
  );

  assign w_last = (r_cnt == c_last);
  assign w_run  = (r_state == ST_RUN);

  // Ripple incrementer keeps the counter free of arithmetic operators
  always_comb begin
    logic cy;
    cy        = 1'b1;
    w_cnt_inc = '0;
    for (int i = 0; i < c_cnt_w; i++) begin
      w_cnt_inc[i] = r_cnt[i] ^ cy;
      cy           = r_cnt[i] & cy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The partial result needs only WIDTH-1 stored bits; the last sum bit
  // comes straight from the adder cell on the final edge.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_s;
    end else begin : g_res_wn
      logic [WIDTH-2:0] r_part;

      assign w_res_next = {w_s, r_part};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_part <= '0;
        end else if (w_run) begin
          r_part <= w_res_next[WIDTH-1:1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_sh_a  <= a;
      r_sh_b  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_sh_a  <= r_sh_a >> 1;
      r_sh_b  <= r_sh_b >> 1;
      r_carry <= w_c;
      r_cnt   <= w_cnt_inc;
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_c;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_8bit.sv
//------------------------------------------------------------------
// tb_serial_adder_8bit : directed self-checking bench, WIDTH=8 and 1
// Revision: 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_serial_adder_8bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int checks = 0;
  int errors = 0;
  int lat;
  int lat2;

  serial_adder_8bit #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_8bit #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with a one-cycle start, then scramble the inputs.
  task automatic start8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
    a     = va;
    b     = vb;
    cin   = vc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("done_after_accept", done, 0);
  endtask

  task automatic wait8(output int n);
    logic [7:0] s0;
    logic       c0;
    logic       stable;
    logic       excl;
    s0     = sum;
    c0     = cout;
    stable = 1'b1;
    excl   = 1'b1;
    n      = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (done !== 1'b1 && (sum !== s0 || cout !== c0)) stable = 1'b0;
      if (busy === 1'b1 && done === 1'b1) excl = 1'b0;
    end
    chk("sum_held_in_run", stable, 1);
    chk("busy_done_excl", excl, 1);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_cout", cout, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_sum1", sum1, 0);

    // Start on the very first edge after reset release
    rst_n = 1'b1;
    start8(8'h0F, 8'h01, 1'b0);
    wait8(lat);
    chk("0f01_latency", lat, 8);
    chk("0f01_sum", sum, 8'h10);
    chk("0f01_cout", cout, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);

    // start held high with changing operands during RUN
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    a = 8'h22;
    b = 8'h11;
    chk("hold_busy", busy, 1);
    wait8(lat);
    chk("hold_first_latency", lat, 8);
    chk("hold_first_sum", sum, 8'h46);
    chk("hold_first_cout", cout, 0);
    @(negedge clk);
    start = 1'b0;
    chk("hold_second_busy", busy, 1);
    chk("hold_second_done", done, 0);
    wait8(lat);
    chk("hold_second_latency", lat, 8);
    chk("hold_second_sum", sum, 8'h33);
    chk("hold_second_cout", cout, 0);

    @(negedge clk);
    start8(8'hFF, 8'h01, 1'b0);
    wait8(lat);
    chk("ff01_sum", sum, 8'h00);
    chk("ff01_cout", cout, 1);
    @(negedge clk);
    start8(8'h3C, 8'h0F, 1'b0);
    wait8(lat);
    chk("3c0f_sum", sum, 8'h4B);
    chk("3c0f_cout", cout, 0);
    @(negedge clk);
    start8(8'hFF, 8'hFF, 1'b1);
    wait8(lat);
    chk("ffff1_sum", sum, 8'hFF);
    chk("ffff1_cout", cout, 1);

    // Reset during the 4th RUN cycle
    @(negedge clk);
    start8(8'hAA, 8'h55, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum, 8'h00);
    chk("midrst_cout", cout, 0);
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
    end
    rst_n = 1'b1;
    start8(8'h03, 8'h04, 1'b0);
    wait8(lat);
    chk("0304_latency", lat, 8);
    chk("0304_sum", sum, 8'h07);
    chk("0304_cout", cout, 0);

    // Back-to-back: second start issued in the DONE cycle
    @(negedge clk);
    start8(8'h80, 8'h80, 1'b0);
    wait8(lat);
    chk("8080_sum", sum, 8'h00);
    chk("8080_cout", cout, 1);
    start8(8'h01, 8'h02, 1'b0);
    wait8(lat2);
    chk("b2b_done_gap", 1 + lat2, 9);
    chk("0102_sum", sum, 8'h03);
    chk("0102_cout", cout, 0);

    // WIDTH=1 instance
    @(negedge clk);
    a1     = 1'b1;
    b1     = 1'b1;
    cin1   = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    cin1   = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_sum_held", sum1, 0);
    @(negedge clk);
    chk("w1_done", done1, 1);
    chk("w1_busy_off", busy1, 0);
    chk("w1_sum", sum1, 1);
    chk("w1_cout", cout1, 1);
    a1     = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_b2b_done_low", done1, 0);
    @(negedge clk);
    chk("w1_b2b_done", done1, 1);
    chk("w1_b2b_sum", sum1, 1);
    chk("w1_b2b_cout", cout1, 0);
    @(negedge clk);
    chk("w1_done_one_cycle", done1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
